multi_voice_osc: RTL and testbench

Parametrised multi-voice tone generator: NUM_VOICES independent oscillators. Each voice is square-wave or LFSR-noise, with a per-voice half-period, a gated linear attack/release envelope, and glitch-free retuning. Voices are summed into one saturated signed sample stream. It sits between the key/tone-selection logic, which writes the config and drives the gates, and the audio codec sample path.

---
 rtl/multi_voice_osc_pkg.sv | 26 ++
 rtl/multi_voice_osc_voice.sv | 105 ++++++++++
 rtl/multi_voice_osc.sv | 88 ++++++++
 tb/tb_multi_voice_osc.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_voice_osc_pkg.sv
// Shared constants for the multi-voice tone generator: mode encodings,
// LFSR seed and taps, envelope ceiling, and the LFSR step function.
package multi_voice_osc_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF    = 2'b00;
  localparam mode_t MODE_SQUARE = 2'b01;
  localparam mode_t MODE_NOISE  = 2'b10;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Zero-based bit positions of the 16,14,13,11 feedback taps
  localparam int unsigned LFSR_TAP_A = 15;
  localparam int unsigned LFSR_TAP_B = 13;
  localparam int unsigned LFSR_TAP_C = 12;
  localparam int unsigned LFSR_TAP_D = 10;

  localparam logic [7:0] LEVEL_MAX = 8'd255;

  // Fibonacci step: shift left, feedback enters at bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
  endfunction

endpackage

// File: rtl/multi_voice_osc_voice.sv
// One oscillator voice: half-period counter, phase, pending/active config,
// noise LFSR, gated linear envelope and the signed voice sample.
// Ports:
//   clk, reset          clock, async active-low reset
//   wr                  decoded config write for this voice
//   wr_half_period      half-period to load into pending
//   wr_mode             mode to load into pending
//   gate                key-down for this voice
//   tick                shared envelope tick
//   sample_c            combinational signed sample (+/-M or 0)
module osc_voice
  import multi_voice_osc_pkg::*;
#(
  parameter int unsigned PERIOD_W  = 20,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned AMPLITUDE = 10_000_000,
  parameter int unsigned VOICE_IDX = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr,
  input  logic [PERIOD_W-1:0]     wr_half_period,
  input  logic [1:0]              wr_mode,
  input  logic                    gate,
  input  logic                    tick,
  output logic signed [OUT_W-1:0] sample_c
);

  localparam int unsigned PROD_W = OUT_W + 8;
  localparam logic [15:0] SEED   = LFSR_SEED + 16'(VOICE_IDX);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] half_period;
  logic [PERIOD_W-1:0] pend_half_period;
  mode_t               mode;
  mode_t               pend_mode;
  logic                phase;
  logic [7:0]          level;
  logic [15:0]         lfsr;

  logic                wrap_c;
  logic                idle_c;
  logic [PROD_W-1:0]   prod_c;
  logic [OUT_W-1:0]    mag_c;

  assign wrap_c = (count >= half_period);
  assign idle_c = (level == 8'd0) && !gate;

  // Counter, phase, LFSR, config staging and envelope
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count            <= '0;
      phase            <= 1'b0;
      half_period      <= '0;
      pend_half_period <= '0;
      mode             <= MODE_OFF;
      pend_mode        <= MODE_OFF;
      level            <= 8'd0;
      lfsr             <= SEED;
    end else begin
      if (wrap_c) begin
        count <= '0;
        phase <= ~phase;
        lfsr  <= lfsr_next(lfsr);
      end else begin
        count <= count + PERIOD_W'(1);
      end

      // Retune only at a half-period boundary or while silent; the copy
      // takes the pending value from before any write on this same edge.
      if (wrap_c || idle_c) begin
        half_period <= pend_half_period;
        mode        <= pend_mode;
      end

      if (wr) begin
        pend_half_period <= wr_half_period;
        pend_mode        <= wr_mode;
      end

      if (tick) begin
        if (gate) begin
          if (level != LEVEL_MAX) level <= level + 8'd1;
        end else begin
          if (level != 8'd0) level <= level - 8'd1;
        end
      end
    end
  end

  // Magnitude = (AMPLITUDE * level) >> 8
  assign prod_c = PROD_W'(AMPLITUDE) * PROD_W'(level);
  assign mag_c  = OUT_W'(prod_c >> 8);

  // Sign selection; reserved mode is silent like off
  always_comb begin
    sample_c = '0;
    case (mode)
      MODE_SQUARE: sample_c = phase   ? $signed(mag_c) : -$signed(mag_c);
      MODE_NOISE:  sample_c = lfsr[0] ? $signed(mag_c) : -$signed(mag_c);
      default:     sample_c = '0;
    endcase
  end

endmodule

// File: rtl/multi_voice_osc.sv
// Multi-voice tone generator top: envelope prescaler, config decode,
// per-voice oscillators, mixer, symmetric saturation and output register.
// Ports:
//   clk, reset          clock, async active-low reset
//   cfg_we              one-cycle config write strobe
//   cfg_voice           target voice (out-of-range values ignored)
//   cfg_half_period     half-period H (phase toggles every H+1 cycles)
//   cfg_mode            00 off, 01 square, 10 noise, 11 off
//   gate                per-voice key-down
//   out                 registered signed mixed sample
module multi_voice_osc
  import multi_voice_osc_pkg::*;
#(
  parameter  int unsigned NUM_VOICES = 4,
  parameter  int unsigned PERIOD_W   = 20,
  parameter  int unsigned OUT_W      = 32,
  parameter  int unsigned AMPLITUDE  = 10_000_000,
  parameter  int unsigned ENV_DIV    = 1000,
  localparam int unsigned VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [VW-1:0]           cfg_voice,
  input  logic [PERIOD_W-1:0]     cfg_half_period,
  input  logic [1:0]              cfg_mode,
  input  logic [NUM_VOICES-1:0]   gate,
  output logic signed [OUT_W-1:0] out
);

  localparam int unsigned PS_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam int unsigned SW   = OUT_W + VW + 1;
  localparam logic signed [SW-1:0] POS_LIM = SW'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [SW-1:0] NEG_LIM = -POS_LIM;

  logic [PS_W-1:0]         presc;
  logic                    tick_c;
  logic signed [OUT_W-1:0] voice_sample_c [NUM_VOICES];
  logic signed [SW-1:0]    psum_c [NUM_VOICES+1];
  logic signed [OUT_W-1:0] sat_c;

  // Shared envelope prescaler
  assign tick_c = (presc == PS_W'(ENV_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) presc <= '0;
    else        presc <= tick_c ? '0 : presc + PS_W'(1);
  end

  assign psum_c[0] = '0;

  // Voices with write decode and running-sum mixer
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    logic wr_c;
    assign wr_c = cfg_we && (cfg_voice == VW'(v));

    osc_voice #(
      .PERIOD_W  (PERIOD_W),
      .OUT_W     (OUT_W),
      .AMPLITUDE (AMPLITUDE),
      .VOICE_IDX (v)
    ) u_voice (
      .clk            (clk),
      .reset          (reset),
      .wr             (wr_c),
      .wr_half_period (cfg_half_period),
      .wr_mode        (cfg_mode),
      .gate           (gate[v]),
      .tick           (tick_c),
      .sample_c       (voice_sample_c[v])
    );

    assign psum_c[v+1] = psum_c[v] + SW'(voice_sample_c[v]);
  end

  // Symmetric clamp so the most negative code is never produced
  always_comb begin
    sat_c = OUT_W'(psum_c[NUM_VOICES]);
    if (psum_c[NUM_VOICES] > POS_LIM)      sat_c = OUT_W'(POS_LIM);
    else if (psum_c[NUM_VOICES] < NEG_LIM) sat_c = OUT_W'(NEG_LIM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out <= '0;
    else        out <= sat_c;
  end

endmodule

// File: tb/tb_multi_voice_osc.sv
// Bench for multi_voice_osc: two instances (4 voices at 10M amplitude and
// 5 voices at full-scale amplitude) driven together, checked every cycle
// against a behavioural model plus hand-computed literal expectations.
module tb_multi_voice_osc;

  localparam int unsigned PERIOD_W = 20;
  localparam int unsigned OUT_W    = 32;
  localparam int unsigned ENV_DIV  = 1;
  localparam int unsigned AMP_A    = 10_000_000;
  localparam int unsigned AMP_B    = 32'h7FFF_FFFF;
  localparam longint      LIM      = 64'sd2147483647;

  logic                    clk;
  logic                    reset;
  logic                    cfg_we;
  logic [1:0]              cfg_voice_a;
  logic [2:0]              cfg_voice_b;
  logic [PERIOD_W-1:0]     cfg_hp;
  logic [1:0]              cfg_mode;
  logic [3:0]              gate;
  logic signed [OUT_W-1:0] out_a;
  logic signed [OUT_W-1:0] out_b;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  multi_voice_osc #(
    .NUM_VOICES(4), .PERIOD_W(PERIOD_W), .OUT_W(OUT_W),
    .AMPLITUDE(AMP_A), .ENV_DIV(ENV_DIV)
  ) u_dut_a (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_voice(cfg_voice_a),
    .cfg_half_period(cfg_hp), .cfg_mode(cfg_mode), .gate(gate), .out(out_a)
  );

  multi_voice_osc #(
    .NUM_VOICES(5), .PERIOD_W(PERIOD_W), .OUT_W(OUT_W),
    .AMPLITUDE(AMP_B), .ENV_DIV(ENV_DIV)
  ) u_dut_b (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_voice(cfg_voice_b),
    .cfg_half_period(cfg_hp), .cfg_mode(cfg_mode), .gate({1'b0, gate}), .out(out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_cnt   [2][5];
  int          m_hp    [2][5];
  int          m_php   [2][5];
  int          m_mode  [2][5];
  int          m_pmode [2][5];
  int          m_phase [2][5];
  int          m_lvl   [2][5];
  logic [15:0] m_lf    [2][5];
  int          m_presc;
  longint      exp_out [2];

  function automatic int nv(input int d);
    return (d == 0) ? 4 : 5;
  endfunction

  function automatic longint amp(input int d);
    return (d == 0) ? longint'(AMP_A) : longint'(AMP_B);
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic longint absv(input longint x);
    return (x < 0) ? -x : x;
  endfunction

  // Expected sample for the current model state
  function automatic longint mix(input int d);
    longint s;
    longint m;
    s = 0;
    for (int v = 0; v < nv(d); v++) begin
      m = (amp(d) * longint'(m_lvl[d][v])) / 256;
      if (m_mode[d][v] == 1)      s += (m_phase[d][v] != 0) ? m : -m;
      else if (m_mode[d][v] == 2) s += m_lf[d][v][0] ? m : -m;
    end
    if (s > LIM)  s = LIM;
    if (s < -LIM) s = -LIM;
    return s;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int v = 0; v < 5; v++) begin
        m_cnt[d][v] = 0;  m_hp[d][v] = 0;   m_php[d][v] = 0;
        m_mode[d][v] = 0; m_pmode[d][v] = 0; m_phase[d][v] = 0;
        m_lvl[d][v] = 0;  m_lf[d][v] = 16'hACE1 + 16'(v);
      end
      exp_out[d] = 0;
    end
    m_presc = 0;
  endtask

  task automatic model_step();
    bit tick, wrap, idle, g;
    int cv;
    tick = (m_presc == int'(ENV_DIV) - 1);
    m_presc = tick ? 0 : m_presc + 1;
    for (int d = 0; d < 2; d++) begin
      exp_out[d] = mix(d);
      cv = (d == 0) ? int'(cfg_voice_a) : int'(cfg_voice_b);
      for (int v = 0; v < nv(d); v++) begin
        g    = (v < 4) ? gate[v] : 1'b0;
        wrap = (m_cnt[d][v] >= m_hp[d][v]);
        idle = (m_lvl[d][v] == 0) && !g;
        if (wrap || idle) begin
          m_hp[d][v]   = m_php[d][v];
          m_mode[d][v] = m_pmode[d][v];
        end
        if (cfg_we && cv == v) begin
          m_php[d][v]   = int'(cfg_hp);
          m_pmode[d][v] = int'(cfg_mode);
        end
        if (wrap) begin
          m_cnt[d][v]   = 0;
          m_phase[d][v] = 1 - m_phase[d][v];
          m_lf[d][v]    = lfsr_step(m_lf[d][v]);
        end else begin
          m_cnt[d][v]++;
        end
        if (tick) begin
          if (g) m_lvl[d][v] = (m_lvl[d][v] < 255) ? m_lvl[d][v] + 1 : 255;
          else   m_lvl[d][v] = (m_lvl[d][v] > 0)   ? m_lvl[d][v] - 1 : 0;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else        model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset && chk_en) begin
        check("model_out_a", longint'(out_a), exp_out[0]);
        check("model_out_b", longint'(out_b), exp_out[1]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the write lands on the following posedge
  task automatic write_cfg(input int va, input int vb, input int hp, input int md);
    cfg_we      = 1'b1;
    cfg_voice_a = 2'(va);
    cfg_voice_b = 3'(vb);
    cfg_hp      = PERIOD_W'(hp);
    cfg_mode    = 2'(md);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Negedges until out_a changes sign; -1 if it never does
  task automatic wait_change(output int n);
    bit s0;
    bit done;
    s0   = (out_a > 0);
    done = 1'b0;
    n    = -1;
    for (int i = 1; i <= 100 && !done; i++) begin
      @(negedge clk);
      if ((out_a > 0) != s0) begin
        n    = i;
        done = 1'b1;
      end
    end
  endtask

  task automatic wait_cnt(input int target, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (m_cnt[0][0] == target) ok = 1'b1;
      else @(negedge clk);
    end
    check(name, longint'(ok), 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    reset = 1'b0; cfg_we = 1'b0; cfg_voice_a = '0; cfg_voice_b = '0;
    cfg_hp = '0; cfg_mode = '0; gate = 4'hF;

    // Reset with gates high and no config
    cycles(3);
    check("reset_out_a", longint'(out_a), 0);
    check("reset_out_b", longint'(out_b), 0);
    reset  = 1'b1;
    chk_en = 1'b1;
    cycles(20);
    check("no_cfg_silent", longint'(out_a), 0);
    gate = 4'h0;
    cycles(260);

    // Voice0 square H=4, attack ramp
    write_cfg(0, 0, 4, 1);
    gate = 4'b0001;
    cycles(255);
    check("ramp_lvl254", absv(longint'(out_a)), 9_921_875);
    cycles(1);
    check("ramp_lvl255", absv(longint'(out_a)), 9_960_937);
    wait_change(n);
    wait_change(n);
    check("half_h4_a", n, 5);
    wait_change(n);
    check("half_h4_b", n, 5);

    // Release ramp
    gate = 4'b0000;
    cycles(255);
    check("release_lvl1", absv(longint'(out_a)), 39_062);
    cycles(1);
    check("release_zero", longint'(out_a), 0);

    // Glitch-free retune: mid-half write, then write on a wrap
    gate = 4'b0001;
    cycles(260);
    wait_cnt(2, "sync_cnt2");
    write_cfg(0, 0, 9, 1);
    wait_change(n);
    check("retune_rest", n, 3);
    wait_change(n);
    check("retune_h9_a", n, 10);
    wait_change(n);
    check("retune_h9_b", n, 10);
    wait_cnt(9, "sync_cnt9");
    write_cfg(0, 0, 3, 1);
    wait_change(n);
    check("wrapwr_edge", n, 1);
    wait_change(n);
    check("wrapwr_old_h", n, 10);
    wait_change(n);
    check("wrapwr_new_h", n, 4);

    // Asynchronous reset mid-tone
    check("pre_rst_tone", longint'(out_a != 0), 1);
    #2 reset = 1'b0;
    gate = 4'h0;
    #1;
    check("async_rst_a", longint'(out_a), 0);
    check("async_rst_b", longint'(out_b), 0);
    @(negedge clk);
    reset = 1'b1;

    // Four aligned square voices, H=7; writes spaced one full period apart
    // so every voice ends up with the same phase.
    for (int v = 0; v < 4; v++) begin
      write_cfg(v, v, 7, 1);
      if (v < 3) cycles(15);
    end
    gate = 4'hF;
    cycles(262);
    check("mix4_a", absv(longint'(out_a)), 39_843_748);
    check("mix4_clamp_b", absv(longint'(out_b)), 2_147_483_647);
    cycles(5);
    check("mix4_a_later", absv(longint'(out_a)), 39_843_748);
    check("mix4_clamp_b_later", absv(longint'(out_b)), 2_147_483_647);

    // Noise voice2 H=0, out-of-range write on instance B, reserved mode
    gate = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    write_cfg(2, 2, 0, 2);
    write_cfg(0, 5, 0, 1);
    gate = 4'b0100;
    cycles(260);
    check("noise_mag_a", absv(longint'(out_a)), 9_960_937);
    check("noise_mag_b", absv(longint'(out_b)), 2_139_095_039);
    cycles(32);
    write_cfg(2, 2, 0, 3);
    cycles(3);
    check("mode11_a", longint'(out_a), 0);
    check("mode11_b", longint'(out_b), 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
